// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART 8N1 receiver: synchronizer, mid-bit sampling FSM, valid/frame_err strobes
module uart_rx #(
    parameter int CLKS_PER_BIT = 1250,
    parameter int SIZE         = 11
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic [SIZE-1:0] HALF_LAST = SIZE'(HALF_BIT - 1);
    localparam logic [SIZE-1:0] BIT_LAST  = SIZE'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state, state_next;
    logic [SIZE-1:0] count, count_next;
    logic [2:0]      bit_idx, bit_idx_next;
    logic [7:0]      shift_reg, shift_next;
    logic [7:0]      data_next;
    logic            valid_next, ferr_next;
    logic            rx_meta, rx_s;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            count     <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            state     <= state_next;
            count     <= count_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_next;
            data_out  <= data_next;
            valid     <= valid_next;
            frame_err <= ferr_next;
        end
    end

    // The counter free-runs inside a bit and is cleared at every sample point.
    always_comb begin
        state_next   = state;
        count_next   = count + 1'b1;
        bit_idx_next = bit_idx;
        shift_next   = shift_reg;
        data_next    = data_out;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        case (state)
            IDLE: begin
                count_next = '0;
                if (!rx_s) state_next = START;
            end
            START: begin
                if (count == HALF_LAST) begin
                    count_next   = '0;
                    bit_idx_next = '0;
                    state_next   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (count == BIT_LAST) begin
                    count_next          = '0;
                    shift_next[bit_idx] = rx_s;
                    bit_idx_next        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_next = STOP;
                end
            end
            STOP: begin
                if (count == BIT_LAST) begin
                    count_next = '0;
                    if (rx_s) begin
                        data_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low break must not be mistaken for a new start bit.
                count_next = '0;
                if (rx_s) state_next = IDLE;
            end
            default: begin
                count_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx against an expected-event queue
module tb_uart_rx;

    localparam int BIT = 16;

    logic       clk_in = 1'b0;
    logic       rst    = 1'b1;
    logic       rx     = 1'b1;
    logic [7:0] data_out;
    logic       valid, frame_err, busy;

    uart_rx #(.CLKS_PER_BIT(BIT), .SIZE(5)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          fall_cyc = 0;
    int          last_valid_cyc = 0;
    int          prev_valid_cyc = 0;
    logic [7:0]  exp_data = 8'h00;
    logic [8:0]  exp_q[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Each strobe must match the oldest outstanding expected event.
    always @(negedge clk_in) begin
        logic [8:0] ev;
        if (!rst && (valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'd0, valid, frame_err}, 32'd0);
            end else begin
                ev = exp_q.pop_front();
                check("strobe_kind", {30'd0, valid, frame_err}, ev[8] ? 32'd1 : 32'd2);
                if (valid) begin
                    check("data_out", {24'd0, data_out}, {24'd0, ev[7:0]});
                    check("busy_on_valid", {31'd0, busy}, 32'd0);
                    exp_data       = ev[7:0];
                    prev_valid_cyc = last_valid_cyc;
                    last_valid_cyc = cyc;
                end else begin
                    check("data_held", {24'd0, data_out}, {24'd0, exp_data});
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        exp_q.push_back({~stop_bit, b});
        rx = 1'b0;
        fall_cyc = cyc;
        wait_cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(BIT);
        end
        rx = stop_bit;
        wait_cycles(BIT);
        rx = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk_in);
        check(tag, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"}, {24'd0, data_out}, {24'd0, exp_data});
        check({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic       ok;

        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(1);
        check_idle_outputs("reset");
        wait_cycles(100);
        check_idle_outputs("reset_100");

        send_frame(8'hA5, 1'b1);
        wait_drain("drain_a5");
        check("data_a5", {24'd0, data_out}, 32'h0000_00A5);
        check("latency", last_valid_cyc - fall_cyc, 32'd155);
        wait_cycles(20);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_drain("drain_b2b");
        check("b2b_spacing", last_valid_cyc - prev_valid_cyc, 32'd160);
        check("data_ff", {24'd0, data_out}, 32'h0000_00FF);
        wait_cycles(20);

        rx = 1'b0;
        wait_cycles(4);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        wait_cycles(20);
        check_idle_outputs("glitch");
        send_frame(8'h3C, 1'b1);
        wait_drain("drain_3c");
        wait_cycles(10);

        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        wait_cycles(40);
        wait_drain("drain_ferr");
        check("ferr_busy_hold", {31'd0, busy}, 32'd1);
        check("ferr_data_kept", {24'd0, data_out}, 32'h0000_003C);
        rx = 1'b1;
        wait_cycles(5);
        check_idle_outputs("after_break");
        send_frame(8'h81, 1'b1);
        wait_drain("drain_81");
        wait_cycles(10);

        // Aborted 0xC3: start plus data bits 0..3, then reset half way through bit 4.
        b  = 8'hC3;
        rx = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_cycles(BIT);
        end
        rx = b[4];
        wait_cycles(BIT / 2);
        rst = 1'b1;
        rx  = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        exp_data = 8'h00;
        wait_cycles(1);
        check_idle_outputs("mid_reset");
        wait_cycles(200);
        check_idle_outputs("mid_reset_quiet");
        send_frame(8'h7E, 1'b1);
        wait_drain("drain_7e");
        check("data_7e", {24'd0, data_out}, 32'h0000_007E);

        for (int n = 0; n < 24; n++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 4) != 0);
            send_frame(b, ok);
            if (ok) wait_cycles($urandom_range(0, 20));
            else    wait_cycles($urandom_range(4, 20));
        end
        wait_drain("drain_random");
        wait_cycles(10);
        check_idle_outputs("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART 8N1 receiver; the receive-side counterpart of the board's uart_tx path on the iCE40-HX8K breakout.
- Synchronizes the asynchronous rx line and validates the start bit at mid-bit.
- Samples 8 data bits LSB-first and checks the stop bit.
- Presents each byte with a one-cycle valid strobe; flags framing errors.

Parameters:
- CLKS_PER_BIT, 1250, clk_in cycles per bit (12 MHz / 9600 baud); must be >= 4.
- SIZE, 11, bit-counter width; 2^SIZE > CLKS_PER_BIT.
- HALF_BIT, CLKS_PER_BIT/2, start-bit mid-point offset (derived, not overridden).

Ports:
- clk_in  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- rx  input  1  serial line; async to clk_in; idle high.
- data_out  output  8  last correctly framed byte; held until the next good frame.
- valid  output  1  one-cycle strobe, data_out updated this cycle.
- frame_err  output  1  one-cycle strobe, stop bit sampled low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clocking and reset:
  - One clock domain; reset is synchronous and active-high.
  - When rst is high at a clk_in edge: state=IDLE, count=0, bit index=0, shift reg=0.
  - Also on reset: data_out=0, valid=0, frame_err=0, busy=0, both sync FFs=1.
  - rst overrides everything, including mid-frame; no partial byte is emitted.
- Synchronizer:
  - rx passes through 2 FFs (rx_s); 2-cycle input latency.
  - All decisions use rx_s only.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - count=0.
  - rx_s==0 -> START.
  - Call this cycle t0.
- START:
  - count increments every cycle.
  - At HALF_BIT cycles after t0, sample rx_s.
  - Sample 0 -> DATA, count=0, bit index=0.
  - Sample 1 -> IDLE (glitch rejected, no strobe).
- DATA:
  - Sample every CLKS_PER_BIT cycles after the previous sample.
  - Shift the sample into bit[index], LSB first.
  - After index 7 is sampled -> STOP.
- STOP:
  - Sample CLKS_PER_BIT cycles after bit 7.
  - Stop=1: on the next edge data_out<=shift reg, valid=1 for exactly one cycle, go to IDLE.
  - Stop=0: on the next edge frame_err=1 for one cycle, data_out unchanged, valid=0, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s==1, then IDLE.
  - Prevents a break condition from re-triggering as a start bit.
- Timing:
  - Sample k (start=0, data=1..8, stop=9) occurs at t0 + HALF_BIT + k*CLKS_PER_BIT.
  - Strobe occurs 1 cycle after sample 9.
- Back-to-back frames:
  - After a good stop the FSM is IDLE mid-stop-bit.
  - A start edge immediately after the stop bit is detected with no lost frame.
- valid and frame_err are never high in the same cycle; both are low outside their strobe cycle.
- busy=1 in START, DATA, STOP and WAIT_HIGH; 0 in IDLE.
  - busy drops on the same edge that raises valid.
- Counter:
  - Unsigned SIZE bits.
  - Cleared on every sample and on every state entry.
  - Never wraps in legal operation.
- No parity, no oversampling majority vote, no FIFO.
  - A byte not consumed on its valid cycle remains readable on data_out until the next good frame.

Test Plan (CLKS_PER_BIT=16, SIZE=5, bit period 16 clocks):
1. Hold rst=1 for 3 cycles with rx=1, then release -> data_out=0x00, valid=0, frame_err=0, busy=0; still so 100 cycles later.
2. Send 0xA5 (start, bits 1,0,1,0,0,1,0,1, stop=1) -> exactly one valid pulse, data_out=0xA5, frame_err never 1, busy low on the valid cycle.
3. Send 0x00 then 0xFF with no idle between frames -> two valid pulses exactly 160 cycles apart (10 bit periods); data_out=0x00 then 0xFF.
4. Drive rx low for 4 cycles then high -> busy pulses briefly, returns to IDLE; no valid, no frame_err; a following 0x3C frame is received correctly.
5. Send 0x55 with stop bit=0, holding rx low 40 more cycles -> frame_err one-cycle pulse, valid=0, data_out keeps the prior value (0x3C), busy stays 1 until rx returns high; next frame 0x81 gives valid with data_out=0x81.
6. Start 0xC3, assert rst for 1 cycle during data bit 4, then release with rx=1 -> all outputs at reset values, no valid for the aborted frame; subsequent 0x7E frame gives valid with data_out=0x7E.
